// File: rtl/planificador_pisos_pkg.sv
// Shared definitions for the floor scheduler and the elevator FSM.
package planificador_pisos_pkg;

   localparam int unsigned N_PISOS_DEF = 4;

   // Command codes sent to the elevator FSM
   typedef enum logic [1:0] {
      ACC_REPOSO  = 2'b00,
      ACC_LLEGADO = 2'b01,
      ACC_SUBIR   = 2'b10,
      ACC_BAJAR   = 2'b11
   } accion_t;

   // Scheduler states; encoding matches the command each state emits
   typedef enum logic [1:0] {
      EST_REPOSO   = 2'b00,
      EST_LLEGADA  = 2'b01,
      EST_SUBIENDO = 2'b10,
      EST_BAJANDO  = 2'b11
   } estado_t;

   // Command emitted while sitting in a given state
   function automatic accion_t accion_de_estado(input estado_t e);
      accion_t a;
      case (e)
         EST_SUBIENDO: a = ACC_SUBIR;
         EST_BAJANDO:  a = ACC_BAJAR;
         EST_LLEGADA:  a = ACC_LLEGADO;
         default:      a = ACC_REPOSO;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/planificador_pisos_buscador_solicitudes.sv
// Locates pending calls relative to the current floor.
module buscador_solicitudes
   import planificador_pisos_pkg::*;
#(
   parameter int unsigned N_PISOS = N_PISOS_DEF
) (
   input  logic [N_PISOS-1:0]         solicitudes,
   input  logic [$clog2(N_PISOS)-1:0] piso,
   output logic                       hay_arriba,
   output logic                       hay_abajo,
   output logic                       pendiente_aqui
);

   localparam int unsigned PISO_W = $clog2(N_PISOS);

   // Scan every floor and classify pending calls as above or below
   always_comb begin
      hay_arriba = 1'b0;
      hay_abajo  = 1'b0;
      for (int unsigned i = 0; i < N_PISOS; i++) begin
         if (solicitudes[i] && (PISO_W'(i) > piso)) hay_arriba = 1'b1;
         if (solicitudes[i] && (PISO_W'(i) < piso)) hay_abajo  = 1'b1;
      end
   end

   assign pendiente_aqui = solicitudes[piso];

endmodule

// File: rtl/planificador_pisos.sv
// SCAN floor scheduler: latches calls, tracks floor, commands the elevator FSM.
module planificador_pisos
   import planificador_pisos_pkg::*;
#(
   parameter int unsigned N_PISOS = N_PISOS_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       habilita,
   input  logic [N_PISOS-1:0]         boton_piso,
   input  logic [N_PISOS-1:0]         sensor_piso,
   input  logic                       ready,
   output logic [1:0]                 accion,
   output logic [N_PISOS-1:0]         solicitudes,
   output logic [$clog2(N_PISOS)-1:0] piso_actual
);

   localparam int unsigned PISO_W = $clog2(N_PISOS);
   localparam int unsigned CNT_W  = $clog2(N_PISOS + 1);

   estado_t             estado_q, estado_sig;
   accion_t             accion_q, accion_sig;
   logic                dir_subir_q, dir_subir_sig;
   logic [N_PISOS-1:0]  solicitudes_q, solicitudes_sig;
   logic [PISO_W-1:0]   piso_q, piso_sig;
   logic [PISO_W-1:0]   piso_sensor, piso_efectivo;
   logic [CNT_W-1:0]    n_activos;
   logic                sensor_valido;
   logic                hay_arriba, hay_abajo, pendiente_aqui;

   buscador_solicitudes #(.N_PISOS(N_PISOS)) u_buscador (
      .solicitudes    (solicitudes_q),
      .piso           (piso_q),
      .hay_arriba     (hay_arriba),
      .hay_abajo      (hay_abajo),
      .pendiente_aqui (pendiente_aqui)
   );

   // Decode the floor sensor; only an exactly one-hot reading is trusted
   always_comb begin
      n_activos   = '0;
      piso_sensor = '0;
      for (int unsigned i = 0; i < N_PISOS; i++) begin
         if (sensor_piso[i]) begin
            n_activos   = n_activos + CNT_W'(1);
            piso_sensor = PISO_W'(i);
         end
      end
      sensor_valido = (n_activos == CNT_W'(1));
      piso_efectivo = sensor_valido ? piso_sensor : piso_q;
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) estado_q <= EST_REPOSO;
      else        estado_q <= estado_sig;
   end

   // Next-state logic: idle dispatch, stop detection and SCAN continuation
   always_comb begin
      estado_sig = estado_q;
      case (estado_q)
         EST_REPOSO: begin
            if (pendiente_aqui)  estado_sig = EST_LLEGADA;
            else if (hay_arriba) estado_sig = EST_SUBIENDO;
            else if (hay_abajo)  estado_sig = EST_BAJANDO;
         end
         EST_SUBIENDO: begin
            if ((sensor_valido && solicitudes_q[piso_sensor]) ||
                (piso_efectivo == PISO_W'(N_PISOS - 1)))
               estado_sig = EST_LLEGADA;
         end
         EST_BAJANDO: begin
            if ((sensor_valido && solicitudes_q[piso_sensor]) ||
                (piso_efectivo == '0))
               estado_sig = EST_LLEGADA;
         end
         EST_LLEGADA: begin
            if (ready) begin
               if (dir_subir_q && hay_arriba)       estado_sig = EST_SUBIENDO;
               else if (!dir_subir_q && hay_abajo)  estado_sig = EST_BAJANDO;
               else if (hay_arriba)                 estado_sig = EST_SUBIENDO;
               else if (hay_abajo)                  estado_sig = EST_BAJANDO;
               else                                 estado_sig = EST_REPOSO;
            end
         end
         default: estado_sig = EST_REPOSO;
      endcase
   end

   // Output logic: command for the upcoming state and remembered direction
   always_comb begin
      accion_sig    = accion_de_estado(estado_sig);
      dir_subir_sig = dir_subir_q;
      if (estado_sig == EST_SUBIENDO) dir_subir_sig = 1'b1;
      if (estado_sig == EST_BAJANDO)  dir_subir_sig = 1'b0;
   end

   // Call register and floor tracking; arrival clear beats a coincident press
   always_comb begin
      solicitudes_sig = solicitudes_q | (habilita ? boton_piso : '0);
      if ((estado_q == EST_LLEGADA) && ready) solicitudes_sig[piso_q] = 1'b0;
      piso_sig = sensor_valido ? piso_sensor : piso_q;
   end

   // Registered outputs and datapath
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         accion_q      <= ACC_REPOSO;
         dir_subir_q   <= 1'b1;
         solicitudes_q <= '0;
         piso_q        <= '0;
      end else begin
         accion_q      <= accion_sig;
         dir_subir_q   <= dir_subir_sig;
         solicitudes_q <= solicitudes_sig;
         piso_q        <= piso_sig;
      end
   end

   assign accion      = accion_q;
   assign solicitudes = solicitudes_q;
   assign piso_actual = piso_q;

endmodule

// File: tb/tb_planificador_pisos.sv
// Self-checking bench for planificador_pisos: directed scenarios plus a random car plant.
module tb_planificador_pisos;

   localparam int N = 4;
   localparam int M_REPOSO = 0, M_SUBE = 1, M_BAJA = 2, M_LLEGA = 3;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         habilita = 1'b0;
   logic         ready = 1'b0;
   logic [N-1:0] boton_piso = '0;
   logic [N-1:0] sensor_piso = '0;
   logic [1:0]   accion;
   logic [N-1:0] solicitudes;
   logic [1:0]   piso_actual;

   always #5 clk = ~clk;

   planificador_pisos #(.N_PISOS(N)) dut (
      .clk         (clk),
      .reset       (reset),
      .habilita    (habilita),
      .boton_piso  (boton_piso),
      .sensor_piso (sensor_piso),
      .ready       (ready),
      .accion      (accion),
      .solicitudes (solicitudes),
      .piso_actual (piso_actual)
   );

   int ncomp = 0;
   int nfail = 0;

   // Reference model: set of pending floors, last floor, travel mode, direction
   bit m_pend [N];
   int m_floor;
   int m_modo;
   bit m_dir_up;
   int car_pos;

   function automatic logic [1:0] codigo(input int modo);
      case (modo)
         M_SUBE:  return 2'b10;
         M_BAJA:  return 2'b11;
         M_LLEGA: return 2'b01;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [N-1:0] pend_vec();
      logic [N-1:0] v = '0;
      for (int i = 0; i < N; i++) v[i] = m_pend[i];
      return v;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncomp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
      m_floor  = 0;
      m_modo   = M_REPOSO;
      m_dir_up = 1'b1;
   endtask

   // Advance the model by one clock using the inputs currently applied
   task automatic model_step();
      int  ones = 0, sfloor = 0, vis, nmodo;
      bit  valid, up = 0, dn = 0, seguir, volver;
      for (int i = 0; i < N; i++) if (sensor_piso[i]) begin ones++; sfloor = i; end
      valid = (ones == 1);
      vis   = valid ? sfloor : m_floor;
      for (int i = 0; i < N; i++) if (m_pend[i]) begin
         if (i > m_floor) up = 1;
         if (i < m_floor) dn = 1;
      end
      seguir = m_dir_up ? up : dn;
      volver = m_dir_up ? dn : up;
      nmodo  = m_modo;
      case (m_modo)
         M_REPOSO: nmodo = m_pend[m_floor] ? M_LLEGA : up ? M_SUBE : dn ? M_BAJA : M_REPOSO;
         M_SUBE:   if ((valid && m_pend[sfloor]) || vis == N - 1) nmodo = M_LLEGA;
         M_BAJA:   if ((valid && m_pend[sfloor]) || vis == 0)     nmodo = M_LLEGA;
         default:  if (ready) begin
            if (seguir)      nmodo = m_dir_up ? M_SUBE : M_BAJA;
            else if (volver) nmodo = m_dir_up ? M_BAJA : M_SUBE;
            else             nmodo = M_REPOSO;
         end
      endcase
      if (habilita) for (int i = 0; i < N; i++) if (boton_piso[i]) m_pend[i] = 1'b1;
      if (m_modo == M_LLEGA && ready) m_pend[m_floor] = 1'b0;
      m_floor = vis;
      if (nmodo == M_SUBE) m_dir_up = 1'b1;
      if (nmodo == M_BAJA) m_dir_up = 1'b0;
      m_modo = nmodo;
   endtask

   task automatic cycle(input string tag);
      model_step();
      @(posedge clk);
      #1;
      check({tag, ".accion"},      32'(accion),      32'(codigo(m_modo)));
      check({tag, ".solicitudes"}, 32'(solicitudes), 32'(pend_vec()));
      check({tag, ".piso"},        32'(piso_actual), 32'(m_floor));
   endtask

   task automatic paso(input logic [N-1:0] bot, input logic [N-1:0] sen,
                       input logic rdy, input string tag);
      boton_piso  = bot;
      sensor_piso = sen;
      ready       = rdy;
      cycle(tag);
   endtask

   initial begin
      logic [N-1:0] s;
      model_reset();
      habilita    = 1'b1;
      sensor_piso = 4'b0001;
      repeat (3) @(posedge clk);
      #1;
      check("rst.accion", 32'(accion), 32'd0);
      check("rst.sol",    32'(solicitudes), 32'd0);
      check("rst.piso",   32'(piso_actual), 32'd0);
      reset = 1'b1;

      // Call to floor 2 from idle at floor 0
      paso(4'b0000, 4'b0001, 0, "idle");
      paso(4'b0100, 4'b0001, 0, "press2");
      check("press2.sol", 32'(solicitudes), 32'h4);
      paso(4'b0000, 4'b0001, 0, "dispatch");
      check("dispatch.subir", 32'(accion), 32'h2);
      paso(4'b0000, 4'b0000, 0, "between01");
      paso(4'b0000, 4'b0010, 0, "pass1");
      check("pass1.piso", 32'(piso_actual), 32'd1);
      paso(4'b0000, 4'b0000, 0, "between12");
      paso(4'b0000, 4'b0100, 0, "arrive2");
      check("arrive2.accion", 32'(accion), 32'h1);
      paso(4'b0000, 4'b0100, 1, "ready2");
      check("ready2.sol",    32'(solicitudes), 32'h0);
      check("ready2.accion", 32'(accion), 32'h0);

      // Move down to floor 1
      paso(4'b0010, 4'b0100, 0, "press1");
      paso(4'b0000, 4'b0100, 0, "down1");
      check("down1.bajar", 32'(accion), 32'h3);
      paso(4'b0000, 4'b0000, 0, "between21");
      paso(4'b0000, 4'b0010, 0, "arrive1");
      check("arrive1.accion", 32'(accion), 32'h1);
      paso(4'b0000, 4'b0010, 1, "ready1");

      // Call at the current floor while idle
      paso(4'b0010, 4'b0010, 0, "same1");
      check("same1.sol", 32'(solicitudes), 32'h2);
      paso(4'b0000, 4'b0010, 0, "same1.arr");
      check("same1.llegado", 32'(accion), 32'h1);
      paso(4'b0000, 4'b0010, 0, "same1.hold");
      check("same1.hold", 32'(accion), 32'h1);
      paso(4'b0000, 4'b0010, 1, "same1.ready");
      check("same1.clr", 32'(solicitudes), 32'h0);

      // SCAN: calls at 0 and 3 from floor 1, serve 3 first
      paso(4'b1001, 4'b0010, 0, "scan.press");
      paso(4'b0000, 4'b0010, 0, "scan.up");
      check("scan.up_first", 32'(accion), 32'h2);
      paso(4'b0000, 4'b0000, 0, "scan.b12");
      paso(4'b0000, 4'b0100, 0, "scan.pass2");
      check("scan.keep_up", 32'(accion), 32'h2);
      paso(4'b0000, 4'b0000, 0, "scan.b23");
      paso(4'b0000, 4'b1000, 0, "scan.at3");
      check("scan.stop3", 32'(accion), 32'h1);
      check("scan.piso3", 32'(piso_actual), 32'd3);
      paso(4'b0000, 4'b1000, 1, "scan.rdy3");
      check("scan.reverse", 32'(accion), 32'h3);
      check("scan.left0", 32'(solicitudes), 32'h1);
      paso(4'b0000, 4'b0000, 0, "scan.b32");
      paso(4'b0000, 4'b0100, 0, "scan.p2");
      paso(4'b0000, 4'b0000, 0, "scan.b21");
      paso(4'b0000, 4'b0010, 0, "scan.p1");
      paso(4'b0000, 4'b0000, 0, "scan.b10");
      paso(4'b0000, 4'b0001, 0, "scan.at0");
      check("scan.stop0", 32'(accion), 32'h1);
      paso(4'b0000, 4'b0001, 1, "scan.rdy0");
      check("scan.idle", 32'(accion), 32'h0);

      // Press at current floor on the same cycle as the arrival clear
      paso(4'b0100, 4'b0001, 0, "clr.press");
      paso(4'b0000, 4'b0001, 0, "clr.up");
      paso(4'b0000, 4'b0010, 0, "clr.p1");
      paso(4'b0000, 4'b0100, 0, "clr.at2");
      paso(4'b0100, 4'b0100, 1, "clr.race");
      check("clr.race_sol", 32'(solicitudes), 32'h0);
      paso(4'b0000, 4'b0100, 0, "clr.after");
      check("clr.after_sol", 32'(solicitudes), 32'h0);

      // Disabled register, multi-hot sensor, stray ready while idle
      habilita = 1'b0;
      paso(4'b1000, 4'b0100, 0, "dis.press");
      paso(4'b0000, 4'b0100, 0, "dis.hold");
      check("dis.sol",    32'(solicitudes), 32'h0);
      check("dis.accion", 32'(accion), 32'h0);
      paso(4'b0000, 4'b0110, 0, "multihot");
      check("multihot.piso", 32'(piso_actual), 32'd2);
      habilita = 1'b1;
      paso(4'b0000, 4'b0100, 1, "stray_ready");
      check("stray_ready.accion", 32'(accion), 32'h0);

      // Asynchronous reset in the middle of travel
      paso(4'b1001, 4'b0100, 0, "ar.press");
      paso(4'b0000, 4'b0100, 0, "ar.up");
      check("ar.moving", 32'(accion), 32'h2);
      paso(4'b0000, 4'b0000, 0, "ar.between");
      #3 reset = 1'b0;
      #1;
      check("ar.accion", 32'(accion), 32'h0);
      check("ar.sol",    32'(solicitudes), 32'h0);
      check("ar.piso",   32'(piso_actual), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      model_reset();
      car_pos = 0;
      paso(4'b0000, 4'b0001, 0, "ar.release");

      // Random traffic with a simple car plant following the expected command
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) begin
            #2 reset = 1'b0;
            #1;
            check("rnd.rst_accion", 32'(accion), 32'h0);
            check("rnd.rst_sol",    32'(solicitudes), 32'h0);
            @(posedge clk);
            #1;
            reset = 1'b1;
            model_reset();
            car_pos = 0;
         end
         habilita   = ($urandom_range(9) != 0);
         boton_piso = ($urandom_range(3) == 0) ? N'($urandom) : '0;
         ready      = (m_modo == M_LLEGA) ? ($urandom_range(2) == 0) : ($urandom_range(15) == 0);
         s = '0;
         if (car_pos % 2 == 0) s[car_pos / 2] = 1'b1;
         if ($urandom_range(24) == 0) s[$urandom_range(N - 1)] = 1'b1;
         sensor_piso = s;
         cycle("rnd");
         if (m_modo == M_SUBE && car_pos < 2 * (N - 1) && $urandom_range(1) == 1) car_pos++;
         if (m_modo == M_BAJA && car_pos > 0 && $urandom_range(1) == 1) car_pos--;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
      $finish;
   end

endmodule
